mem_port_arbiter: RTL

- Shares the single-port 8-bit program/data RAM between two requesters: the CPU datapath (instruction fetch, immediate fetch, load/store) and a DMA/program-loader port that fills RAM before and during execution.
- Decides ownership each cycle, drives the RAM address, data and write-enable, and returns read data with a valid strobe.
- Emits a stall to the CPU phase counter while a CPU access is pending.

---
 rtl/mem_port_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// =============================================================================
// Module  : mem_port_arbiter
// Brief   : Shares one single-port synchronous RAM between CPU and DMA ports.
// Rev     : 1.0
// =============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic              dma_lock,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_OWN_CPU = 2'd1;
    localparam logic [1:0] c_OWN_DMA = 2'd2;

    localparam int               CNT_W       = 4;
    localparam logic [CNT_W-1:0] c_MAX_BURST = CNT_W'(MAX_BURST);

    logic [1:0]        state_q, state_d;
    logic              last_dma_q, last_dma_d;
    logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;
    logic              rtag_valid_q;
    logic              rtag_dma_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] dma_rdata_q;

    // burst_cnt counts DMA grants issued while the CPU waits, including the
    // grant now being entered, so a locked burst yields exactly MAX_BURST grants.
    always_comb begin
        state_d = c_IDLE;
        if (cpu_req && dma_req) begin
            if (state_q == c_OWN_DMA && dma_lock && burst_cnt_q < c_MAX_BURST) begin
                state_d = c_OWN_DMA;
            end else if (last_dma_q) begin
                state_d = c_OWN_CPU;
            end else begin
                state_d = c_OWN_DMA;
            end
        end else if (cpu_req) begin
            state_d = c_OWN_CPU;
        end else if (dma_req) begin
            state_d = c_OWN_DMA;
        end
    end

    always_comb begin
        last_dma_d  = last_dma_q;
        burst_cnt_d = '0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        if (state_d == c_OWN_CPU) begin
            last_dma_d  = 1'b0;
            mem_addr_d  = cpu_addr;
            mem_wdata_d = cpu_wdata;
            mem_we_d    = cpu_we;
        end else if (state_d == c_OWN_DMA) begin
            last_dma_d  = 1'b1;
            mem_addr_d  = dma_addr;
            mem_wdata_d = dma_wdata;
            mem_we_d    = dma_we;
            if (cpu_req) begin
                burst_cnt_d = (burst_cnt_q < c_MAX_BURST) ? burst_cnt_q + 1'b1 : burst_cnt_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= c_IDLE;
            last_dma_q   <= 1'b1;
            burst_cnt_q  <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
            rtag_valid_q <= 1'b0;
            rtag_dma_q   <= 1'b0;
            cpu_rdata_q  <= '0;
            dma_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_dma_q   <= last_dma_d;
            burst_cnt_q  <= burst_cnt_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_we_q     <= mem_we_d;
            // Tag the read issued this cycle; the RAM returns it next cycle.
            rtag_valid_q <= (state_q != c_IDLE) && !mem_we_q;
            rtag_dma_q   <= (state_q == c_OWN_DMA);
            if (cpu_rvalid) begin
                cpu_rdata_q <= mem_rdata;
            end
            if (dma_rvalid) begin
                dma_rdata_q <= mem_rdata;
            end
        end
    end

    assign cpu_gnt    = (state_q == c_OWN_CPU);
    assign dma_gnt    = (state_q == c_OWN_DMA);
    assign cpu_stall  = cpu_req & ~cpu_gnt;
    assign cpu_rvalid = rtag_valid_q & ~rtag_dma_q;
    assign dma_rvalid = rtag_valid_q &  rtag_dma_q;
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_q;
    assign dma_rdata  = dma_rvalid ? mem_rdata : dma_rdata_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_we     = mem_we_q;

endmodule

`default_nettype wire
